// File: rtl/byte_en_regfile_if.sv
// rtl/byte_en_regfile_if.sv - write/stream/read bus bundle for byte_en_regfile
interface byte_en_regfile_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
);
    localparam int BYTES = DATA_W / 8;
    localparam int AW    = $clog2(NUM_REGS);
    localparam int BSW   = $clog2(BYTES);

    logic                we;
    logic [AW-1:0]       waddr;
    logic [BSW-1:0]      byte_sel;
    logic [7:0]          d_byte;
    logic                stream_we;
    logic [7:0]          d_stream;
    logic                stream_clr;
    logic                word_done;
    logic [AW-1:0]       word_done_addr;
    logic                re;
    logic [AW-1:0]       raddr;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic [BYTES-1:0]    rpar;
    logic [NUM_REGS-1:0] dirty;

    modport master (
        output we, waddr, byte_sel, d_byte, stream_we, d_stream, stream_clr, re, raddr,
        input  word_done, word_done_addr, rdata, rvalid, rpar, dirty
    );

    modport slave (
        input  we, waddr, byte_sel, d_byte, stream_we, d_stream, stream_clr, re, raddr,
        output word_done, word_done_addr, rdata, rvalid, rpar, dirty
    );
endinterface

// File: rtl/byte_en_regfile.sv
// rtl/byte_en_regfile.sv - byte-lane register bank with direct and streaming writers
// Optional lane parity storage: BYTE_EN_REGFILE_PARITY_EN
module byte_en_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input logic              clk,
    input logic              rst,
    byte_en_regfile_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int AW    = $clog2(NUM_REGS);
    localparam int BSW   = $clog2(BYTES);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [AW-1:0]     sptr_reg;
    logic [BSW-1:0]    sptr_lane;
    logic              last_lane;

    assign last_lane = (sptr_lane == BSW'(BYTES - 1));

`ifdef BYTE_EN_REGFILE_PARITY_EN
    logic [BYTES-1:0] par [NUM_REGS];
`else
    assign bus.rpar = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
`ifdef BYTE_EN_REGFILE_PARITY_EN
                par[i]  <= '0;
`endif
            end
`ifdef BYTE_EN_REGFILE_PARITY_EN
            bus.rpar           <= '0;
`endif
            sptr_reg           <= '0;
            sptr_lane          <= '0;
            bus.word_done      <= 1'b0;
            bus.word_done_addr <= '0;
            bus.rdata          <= '0;
            bus.rvalid         <= 1'b0;
            bus.dirty          <= '0;
        end else begin
            // Read samples pre-write contents since regs update on this same edge
            bus.rvalid <= bus.re;
            if (bus.re) begin
                bus.rdata <= regs[bus.raddr];
`ifdef BYTE_EN_REGFILE_PARITY_EN
                bus.rpar  <= par[bus.raddr];
`endif
            end

            bus.word_done <= 1'b0;
            if (bus.stream_we) begin
                regs[sptr_reg][8*sptr_lane +: 8] <= bus.d_stream;
`ifdef BYTE_EN_REGFILE_PARITY_EN
                par[sptr_reg][sptr_lane] <= ^bus.d_stream;
`endif
                if (last_lane) begin
                    sptr_lane <= '0;
                    sptr_reg  <= sptr_reg + 1'b1;
                    if (!bus.stream_clr) begin
                        bus.word_done      <= 1'b1;
                        bus.word_done_addr <= sptr_reg;
                    end
                end else begin
                    sptr_lane <= sptr_lane + 1'b1;
                end
            end
            if (bus.stream_clr) begin
                sptr_reg  <= '0;
                sptr_lane <= '0;
            end

            // Direct write placed after the stream write so it wins a lane collision
            if (bus.we) begin
                regs[bus.waddr][8*bus.byte_sel +: 8] <= bus.d_byte;
`ifdef BYTE_EN_REGFILE_PARITY_EN
                par[bus.waddr][bus.byte_sel] <= ^bus.d_byte;
`endif
            end

            for (int i = 0; i < NUM_REGS; i++) begin
                if ((bus.we && bus.waddr == AW'(i)) || (bus.stream_we && sptr_reg == AW'(i)))
                    bus.dirty[i] <= 1'b1;
                else if (bus.re && bus.raddr == AW'(i))
                    bus.dirty[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_byte_en_regfile.sv
// tb/tb_byte_en_regfile.sv - randomized and directed check of byte_en_regfile against a byte-array model
module tb_byte_en_regfile;
    localparam int DATA_W = 32;
    localparam int NR     = 4;
    localparam int BYTES  = DATA_W / 8;
    localparam int TOT    = NR * BYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    byte_en_regfile_if #(.DATA_W(DATA_W), .NUM_REGS(NR)) bus ();

    byte_en_regfile #(.DATA_W(DATA_W), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: flat byte memory and a linear byte pointer
    logic [7:0]        mem [TOT];
    int                sp;
    logic [DATA_W-1:0] e_rdata;
    logic [BYTES-1:0]  e_rpar;
    logic [NR-1:0]     e_dirty;
    logic              e_rvalid, e_wd;
    logic [1:0]        e_wda;
    bit                started = 0;

    function automatic logic [DATA_W-1:0] word_of(int r);
        logic [DATA_W-1:0] w;
        for (int b = 0; b < BYTES; b++) w[8*b +: 8] = mem[r*BYTES + b];
        return w;
    endfunction

    function automatic logic [BYTES-1:0] par_of(int r);
        logic [BYTES-1:0] p;
        for (int b = 0; b < BYTES; b++) p[b] = ^mem[r*BYTES + b];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            for (int i = 0; i < TOT; i++) mem[i] = 8'h00;
            sp = 0; e_rdata = '0; e_rpar = '0; e_dirty = '0;
            e_rvalid = 0; e_wd = 0; e_wda = '0;
        end else if (started) begin
            int r;
            e_rvalid = bus.re;
            if (bus.re) begin
                e_rdata = word_of(int'(bus.raddr));
`ifdef BYTE_EN_REGFILE_PARITY_EN
                e_rpar = par_of(int'(bus.raddr));
`else
                e_rpar = '0;
`endif
                e_dirty[bus.raddr] = 1'b0;
            end
            e_wd = 0;
            if (bus.stream_we) begin
                r = sp / BYTES;
                mem[sp] = bus.d_stream;
                e_dirty[r] = 1'b1;
                if (sp % BYTES == BYTES - 1 && !bus.stream_clr) begin
                    e_wd = 1;
                    e_wda = 2'(r);
                end
                sp = (sp + 1) % TOT;
            end
            if (bus.we) begin
                mem[int'(bus.waddr)*BYTES + int'(bus.byte_sel)] = bus.d_byte;
                e_dirty[bus.waddr] = 1'b1;
            end
            if (bus.stream_clr) sp = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rvalid", 64'(bus.rvalid), 64'(e_rvalid));
            chk("rdata", 64'(bus.rdata), 64'(e_rdata));
            chk("rpar", 64'(bus.rpar), 64'(e_rpar));
            chk("dirty", 64'(bus.dirty), 64'(e_dirty));
            chk("word_done", 64'(bus.word_done), 64'(e_wd));
            if (e_wd) chk("word_done_addr", 64'(bus.word_done_addr), 64'(e_wda));
        end
    end

    task automatic tick();
        @(negedge clk);
        rst = 0; bus.we = 0; bus.stream_we = 0; bus.stream_clr = 0; bus.re = 0;
    endtask

    task automatic sbyte(input logic [7:0] d);
        bus.stream_we = 1; bus.d_stream = d; tick();
    endtask

    initial begin
        bus.we = 0; bus.waddr = '0; bus.byte_sel = '0; bus.d_byte = '0;
        bus.stream_we = 0; bus.d_stream = '0; bus.stream_clr = 0;
        bus.re = 0; bus.raddr = '0;
        rst = 1; tick();
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        chk("rst_dirty", 64'(bus.dirty), 64'h0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
        chk("rst_word_done", 64'(bus.word_done), 64'h0);

        // Direct writes to reg1 lanes 0 and 1
        bus.we = 1; bus.waddr = 2'd1; bus.byte_sel = 2'd0; bus.d_byte = 8'h32; tick();
        bus.we = 1; bus.waddr = 2'd1; bus.byte_sel = 2'd1; bus.d_byte = 8'h32; tick();
        chk("t1_dirty_pre", 64'(bus.dirty), 64'b0010);
        bus.re = 1; bus.raddr = 2'd1; tick();
        chk("t1_rdata", 64'(bus.rdata), 64'h0000_3232);
        chk("t1_rvalid", 64'(bus.rvalid), 64'h1);
        chk("t1_dirty_post", 64'(bus.dirty), 64'b0000);

        // Stream assembly and wrap
        sbyte(8'h11); sbyte(8'h22); sbyte(8'h33); sbyte(8'h44);
        chk("t2_wd", 64'(bus.word_done), 64'h1);
        chk("t2_wda", 64'(bus.word_done_addr), 64'h0);
        for (int i = 4; i < 16; i++) begin
            sbyte(8'($urandom));
            if (i % 4 == 3) begin
                chk("t2_wd_n", 64'(bus.word_done), 64'h1);
                chk("t2_wda_n", 64'(bus.word_done_addr), 64'(i / 4));
            end
        end
        sbyte(8'h99);
        bus.re = 1; bus.raddr = 2'd0; tick();
        chk("t2_wrap", 64'(bus.rdata), 64'h4433_2299);

        // Collision on reg2 lane0
        bus.stream_clr = 1; tick();
        for (int i = 0; i < 8; i++) sbyte(8'($urandom));
        bus.we = 1; bus.waddr = 2'd2; bus.byte_sel = 2'd0; bus.d_byte = 8'hAA;
        sbyte(8'h55);
        sbyte(8'h66);
        bus.re = 1; bus.raddr = 2'd2; tick();
        chk("t3_collision", 64'(bus.rdata[15:0]), 64'h66AA);

        // Read and write of reg3 in the same cycle
        rst = 1; tick();
        bus.we = 1; bus.waddr = 2'd3; bus.byte_sel = 2'd0; bus.d_byte = 8'h7F;
        bus.re = 1; bus.raddr = 2'd3; tick();
        chk("t4_rdata_old", 64'(bus.rdata), 64'h0);
        chk("t4_dirty_set", 64'(bus.dirty[3]), 64'h1);
        bus.re = 1; bus.raddr = 2'd3; tick();
        chk("t4_rdata_new", 64'(bus.rdata), 64'h7F);
        chk("t4_dirty_clr", 64'(bus.dirty[3]), 64'h0);

        // Reset mid-stream
        sbyte(8'hE1); sbyte(8'hE2);
        rst = 1; tick();
        chk("t5_wd_rst", 64'(bus.word_done), 64'h0);
        sbyte(8'h01); sbyte(8'h02); sbyte(8'h03); sbyte(8'h04);
        chk("t5_wd", 64'(bus.word_done), 64'h1);
        chk("t5_wda", 64'(bus.word_done_addr), 64'h0);
        bus.re = 1; bus.raddr = 2'd0; tick();
        chk("t5_rdata", 64'(bus.rdata), 64'h0403_0201);

        // stream_clr on the last lane suppresses word_done
        rst = 1; tick();
        sbyte(8'hA0); sbyte(8'hA1); sbyte(8'hA2);
        bus.stream_clr = 1; sbyte(8'hA3);
        chk("t7_wd_clr", 64'(bus.word_done), 64'h0);
        sbyte(8'hB0); sbyte(8'hB1); sbyte(8'hB2); sbyte(8'hB3);
        chk("t7_wda", 64'(bus.word_done_addr), 64'h0);

        // Parity
        rst = 1; tick();
        bus.we = 1; bus.waddr = 2'd0; bus.byte_sel = 2'd0; bus.d_byte = 8'h07; tick();
        bus.we = 1; bus.waddr = 2'd0; bus.byte_sel = 2'd1; bus.d_byte = 8'h03; tick();
        bus.re = 1; bus.raddr = 2'd0; tick();
`ifdef BYTE_EN_REGFILE_PARITY_EN
        chk("t6_rpar", 64'(bus.rpar), 64'b0001);
`else
        chk("t6_rpar", 64'(bus.rpar), 64'b0000);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 299) == 0);
            bus.we         = 1'($urandom);
            bus.waddr      = 2'($urandom);
            bus.byte_sel   = 2'($urandom);
            bus.d_byte     = 8'($urandom);
            bus.stream_we  = 1'($urandom);
            bus.d_stream   = 8'($urandom);
            bus.stream_clr = ($urandom_range(0, 15) == 0);
            bus.re         = 1'($urandom);
            bus.raddr      = 2'($urandom);
            @(negedge clk);
        end
        rst = 0; bus.we = 0; bus.stream_we = 0; bus.stream_clr = 0; bus.re = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/byte_en_regfile.md
Name: byte_en_regfile

Overview:
- Parametrised successor of the single byte-enable register: a bank of NUM_REGS registers, each DATA_W bits wide.
- Each register is written one byte lane at a time through a direct addressed port, or through an auto-incrementing byte-stream port.
- Provides a registered read port and per-register dirty flags.
- Sits between the SD card controller data path and the register/CSR consumers; stores command arguments and response words assembled byte by byte.

Parameters:
- DATA_W, 32: register width in bits. Multiple of 8, >=16; DATA_W/8 must be a power of 2.
- NUM_REGS, 4: number of registers. Power of 2, >=2.
- Derived, not overridable: BYTES=DATA_W/8, AW=$clog2(NUM_REGS), BSW=$clog2(BYTES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  direct byte write strobe
- waddr  in  AW  direct write register index
- byte_sel  in  BSW  direct write byte lane (0 = bits 7:0)
- d_byte  in  8  direct write data
- stream_we  in  1  stream byte write strobe
- d_stream  in  8  stream write data
- stream_clr  in  1  reset stream pointer to reg 0, lane 0
- word_done  out  1  one-cycle pulse: stream completed the last lane of a register
- word_done_addr  out  AW  register completed; valid with word_done
- re  in  1  read request
- raddr  in  AW  read register index
- rdata  out  DATA_W  read data, registered
- rvalid  out  1  one-cycle pulse, one cycle after re
- rpar  out  BYTES  per-lane stored parity (see Optional Feature)
- dirty  out  NUM_REGS  per-register written-since-last-read flags

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - all registers 0; dirty=0; stream pointer = reg 0, lane 0.
  - word_done=0, word_done_addr=0, rdata=0, rvalid=0, rpar=0.
  - rst overrides every other input in that cycle. Reset mid-stream discards the partial word pointer; bytes already written stay cleared (all registers are 0).
- Direct write: on we, reg[waddr] lane byte_sel <= d_byte. Other lanes unchanged. Visible to a read issued the following cycle.
- Stream write: on stream_we, reg[sptr_reg] lane sptr_lane <= d_stream, then lane increments.
  - When lane = BYTES-1: lane wraps to 0, sptr_reg increments, and NUM_REGS-1 wraps to 0.
  - In the same cycle word_done pulses the next cycle, with word_done_addr = the completed register.
- stream_clr: pointer returns to 0/0 at the next edge.
  - stream_clr with stream_we in the same cycle: the write uses the current pointer, then the pointer is forced to 0/0, and no word_done occurs.
- Collision, we and stream_we on the same register and lane: the direct write wins; the stream pointer still advances and word_done still pulses. Different lanes or registers: both writes take effect.
- Read: on re, rdata <= reg[raddr] and rvalid=1 on the next edge. Latency 1. rdata holds its value until the next re or reset.
  - Read and write to the same register in the same cycle: read returns pre-write contents.
- Dirty flags:
  - dirty[i] sets on any write (direct or stream) to reg i.
  - dirty[i] clears on re with raddr=i.
  - Simultaneous write and read of the same register: set wins, dirty stays 1.
- No back-pressure; every strobe is accepted every cycle.

Optional Feature:
- Macro: BYTE_EN_REGFILE_PARITY_EN.
- Defined: each lane stores an even-parity bit (XOR of the byte) on every write. rpar is registered alongside rdata with the same latency, and resets to 0.
- Undefined: no parity storage; rpar is tied to 0. The port is always present.

Test Plan (DATA_W=32, NUM_REGS=4):
- Reset then direct write: rst pulse; we, waddr=1, byte_sel=0, d_byte=8'h32; then we, byte_sel=1, d_byte=8'h32; re raddr=1 -> next cycle rdata=32'h0000_3232, rvalid=1, dirty=4'b0010 before read and 4'b0000 after.
- Stream assembly: stream_we with 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> word_done pulse with word_done_addr=0 one cycle after the 4th byte; reg0=32'h4433_2211; 16 bytes total -> word_done for 0,1,2,3, then the pointer wraps and the 17th byte lands in reg0 lane 0.
- Collision: we waddr=2, byte_sel=0, d_byte=8'hAA together with stream_we to reg2 lane0 d_stream=8'h55 -> reg2[7:0]=8'hAA; next stream byte goes to lane 1.
- Read/write same cycle: reg3=0, we to reg3 lane0 8'h7F with re raddr=3 -> rdata=0, dirty[3]=1; a second re -> rdata=32'h0000_007F, dirty[3]=0.
- Reset mid-stream: 2 stream bytes, rst, then 4 stream bytes 8'h01..8'h04 -> word_done_addr=0, reg0=32'h0403_0201, no word_done during reset.
- Parity (macro defined): write 8'h07 to reg0 lane0 and 8'h03 to lane1 -> re raddr=0 gives rpar=4'b0001; macro undefined -> rpar=0.
